rgb_pwm: RTL

RGB_PWM -- requirements
Module: rgb_pwm

---
 rtl/rgb_pwm_pkg.sv | 22 ++
 rtl/rgb_pwm_channel.sv | 54 +++++
 rtl/rgb_pwm.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pwm_pkg.sv
// ---------------------------------------------------------------------------
// rgb_pwm_pkg
// Shared definitions for the RGB PWM block: duty width, channel count,
// channel index constants and the breathing-envelope state type.
// Imported by rgb_pwm and rgb_pwm_channel.
// ---------------------------------------------------------------------------
package rgb_pwm_pkg;

  localparam int DUTY_W = 8;
  localparam int NUM_CH = 3;

  // Channel slots inside the packed per-channel vectors.
  localparam int R = 0;
  localparam int G = 1;
  localparam int B = 2;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } breathe_state_t;

endpackage

// File: rtl/rgb_pwm_channel.sv
// ---------------------------------------------------------------------------
// rgb_pwm_channel
// One PWM output channel: a 2-flop synchronizer for the asynchronous enable,
// the counter/duty compare and the registered LED output.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en_async  in   asynchronous channel enable
//   pwm_cnt   in   shared PWM step counter
//   eff_duty  in   effective duty for this channel
//   led       out  registered PWM output
//
// Enable-to-output latency is 3 clocks (two sync flops plus the output flop).
// Deassertion acts directly on the output term, so it never waits for a
// period boundary.
// ---------------------------------------------------------------------------
module rgb_pwm_channel
  import rgb_pwm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_async,
  input  logic [DUTY_W-1:0] pwm_cnt,
  input  logic [DUTY_W-1:0] eff_duty,
  output logic              led
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic led_q, led_d;

  always_comb begin
    sync1_d = en_async;
    sync2_d = sync1_q;
    // Strict less-than: duty 0 never lights, duty 255 misses the last step.
    led_d   = sync2_q && (pwm_cnt < eff_duty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      led_q   <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/rgb_pwm.sv
// ---------------------------------------------------------------------------
// rgb_pwm
// Three-channel PWM LED driver with a prescaled 8-bit PWM counter,
// double-buffered duty updates applied only at the period wrap, and an
// optional breathing envelope.
//
// Optional feature macro: RGB_BREATHE_EN
//   defined   -> triangular envelope (UP/DOWN) scales the duties when
//                breathe=1; breathe=0 bypasses it and parks env=0, UP.
//   undefined -> breathe port present but ignored; eff_duty = active duty.
//
// Ports:
//   CLK100MHZ          in   system clock, rising edge
//   CPU_RESETN         in   asynchronous active-low reset
//   en_r/en_g/en_b     in   asynchronous channel enables
//   duty_r/g/b [7:0]   in   requested duties, sampled on update capture
//   upd_req            in   duty-update request (level)
//   upd_ack            out  one-cycle pulse: duty_* captured this cycle
//   breathe            in   breathing-mode select
//   LED17_R/G/B        out  registered PWM outputs
//   period_start       out  one-cycle pulse in the counter wrap cycle
//
// Parameter:
//   PRESCALE_DIV       clocks per PWM step (2..65535)
// ---------------------------------------------------------------------------
module rgb_pwm
  import rgb_pwm_pkg::*;
#(
  parameter int PRESCALE_DIV = 391
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESETN,
  input  logic              en_r,
  input  logic              en_g,
  input  logic              en_b,
  input  logic [DUTY_W-1:0] duty_r,
  input  logic [DUTY_W-1:0] duty_g,
  input  logic [DUTY_W-1:0] duty_b,
  input  logic              upd_req,
  output logic              upd_ack,
  input  logic              breathe,
  output logic              LED17_R,
  output logic              LED17_G,
  output logic              LED17_B,
  output logic              period_start
);

  localparam int              PS_W   = $clog2(PRESCALE_DIV);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE_DIV - 1);

  logic [PS_W-1:0]                 presc_q, presc_d;
  logic [DUTY_W-1:0]               pwm_cnt_q, pwm_cnt_d;
  logic [NUM_CH-1:0][DUTY_W-1:0]   shadow_q, shadow_d;
  logic [NUM_CH-1:0][DUTY_W-1:0]   active_q, active_d;
  logic                            pending_q, pending_d;

  logic                            tick;
  logic                            wrap;
  logic                            capture;
  logic [NUM_CH-1:0][DUTY_W-1:0]   duty_in;
  logic [NUM_CH-1:0][DUTY_W-1:0]   eff_duty;
  logic [NUM_CH-1:0]               en_in;
  logic [NUM_CH-1:0]               led;

  always_comb begin
    duty_in    = '0;
    duty_in[R] = duty_r;
    duty_in[G] = duty_g;
    duty_in[B] = duty_b;
    en_in      = '0;
    en_in[R]   = en_r;
    en_in[G]   = en_g;
    en_in[B]   = en_b;
  end

  // Prescaler and PWM step counter.
  always_comb begin
    tick      = (presc_q == PS_MAX);
    presc_d   = tick ? '0 : presc_q + PS_W'(1);
    pwm_cnt_d = tick ? pwm_cnt_q + DUTY_W'(1) : pwm_cnt_q;
    wrap      = tick && (pwm_cnt_q == '1);
  end

  // Duty double buffer. A capture needs pending=0 and a transfer needs
  // pending=1, so the two never collide in one cycle; a request in the wrap
  // cycle with nothing pending is captured and waits for the next wrap.
  always_comb begin
    capture   = upd_req && !pending_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (capture) begin
      shadow_d  = duty_in;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
    end
  end

`ifdef RGB_BREATHE_EN
  breathe_state_t    state_q, state_d;
  logic [DUTY_W-1:0] env_q, env_d;

  // Scale a duty by the envelope, truncating: (duty*env)>>8.
  function automatic logic [DUTY_W-1:0] scale_duty(input logic [DUTY_W-1:0] duty,
                                                   input logic [DUTY_W-1:0] env);
    logic [2*DUTY_W-1:0] prod;
    prod = duty * env;
    return prod[2*DUTY_W-1:DUTY_W];
  endfunction

  // Envelope steps once per period; it turns around at the extremes so the
  // sequence is 0,1,..,255,254,..,0 without repeating the end values.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (!breathe) begin
      state_d = UP;
      env_d   = '0;
    end else if (wrap) begin
      case (state_q)
        UP: begin
          env_d = env_q + DUTY_W'(1);
          if (env_q == DUTY_W'(254)) state_d = DOWN;
        end
        DOWN: begin
          env_d = env_q - DUTY_W'(1);
          if (env_q == DUTY_W'(1)) state_d = UP;
        end
        default: begin
          state_d = UP;
          env_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= UP;
      env_q   <= '0;
    end else begin
      state_q <= state_d;
      env_q   <= env_d;
    end
  end

  always_comb begin
    eff_duty = active_q;
    if (breathe) begin
      for (int i = 0; i < NUM_CH; i++) begin
        eff_duty[i] = scale_duty(active_q[i], env_q);
      end
    end
  end
`else
  logic unused_breathe;
  assign unused_breathe = breathe;

  always_comb begin
    eff_duty = active_q;
  end
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rgb_pwm_channel u_channel (
      .clk      (CLK100MHZ),
      .rst_n    (CPU_RESETN),
      .en_async (en_in[c]),
      .pwm_cnt  (pwm_cnt_q),
      .eff_duty (eff_duty[c]),
      .led      (led[c])
    );
  end

  assign LED17_R      = led[R];
  assign LED17_G      = led[G];
  assign LED17_B      = led[B];
  assign period_start = wrap;
  // Gated by reset so the acknowledge is low while the block is held in reset.
  assign upd_ack      = capture && CPU_RESETN;

endmodule
